// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receive datapath, validates each frame and keeps sticky error flags
module uart_rx_ctrl #(
    parameter int TIMEOUT = 60000,
    parameter int TO_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy,
    input  logic       shift,
    input  logic [3:0] bit_cnt,
    input  logic       rx_sync,
    input  logic       ready,
    input  logic       rd_ack,
    input  logic       clr_err,
    output logic       start,
    output logic       receiving,
    output logic       clr_busy,
    output logic       set_ready,
    output logic       clr_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RECV   = 3'd2,
        DONE   = 3'd3,
        ABORT  = 3'd4,
        GLITCH = 3'd5
    } state_t;
    state_t cur, nxt;
    logic [TO_W-1:0] to_cnt;
    logic stop_bit;
    logic set_fe, set_ov;
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
            to_cnt <= '0;
            stop_bit <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            cur <= nxt;
            to_cnt <= (cur == START) ? '0 : (cur == RECV) ? to_cnt + 1'b1 : to_cnt;
            if (cur == RECV && shift && bit_cnt == 4'd9)
                stop_bit <= rx_sync;
            frame_err <= set_fe | (frame_err & ~clr_err);
            overrun <= set_ov | (overrun & ~clr_err);
        end
    end
    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE:  nxt = busy ? START : IDLE;
            START: nxt = RECV;
            RECV: begin
                nxt = RECV;
                if (shift && bit_cnt == 4'd0 && rx_sync)
                    nxt = GLITCH;
                else if (shift && bit_cnt == 4'd9)
                    nxt = RECV;
                else if (bit_cnt == 4'd10)
                    nxt = DONE;
                else if (to_cnt == TO_W'(TIMEOUT - 1))
                    nxt = ABORT;
            end
            default: nxt = IDLE;
        endcase
    end
    assign start     = cur == START;
    assign receiving = cur == RECV;
    assign clr_busy  = cur == DONE || cur == ABORT || cur == GLITCH;
    assign set_ready = cur == DONE && stop_bit;
    // a same-cycle ack retires the old byte; suppressing clr_ready keeps the new byte's ready
    assign clr_ready = rd_ack & ~set_ready;
    assign set_fe    = (cur == DONE && !stop_bit) || cur == ABORT;
    assign set_ov    = set_ready & ready & ~rd_ack;
    assign state     = cur;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized frames against a behavioural model, checked through a scoreboard queue
module tb_uart_rx_ctrl;
    localparam int TIMEOUT = 200;
    localparam int B = 16;
    logic clk = 1'b0, rst = 1'b1, busy = 1'b0, shift = 1'b0, rx_sync = 1'b1;
    logic rd_ack = 1'b0, clr_err = 1'b0, ready;
    logic [3:0] bit_cnt = 4'd0;
    logic start, receiving, clr_busy, set_ready, clr_ready, frame_err, overrun;
    logic [2:0] state;
    logic [7:0] sh, cmd;
    int errs = 0, checks = 0;

    typedef struct {
        int kind;
        logic sr, cr, fe, ov, rdy;
        logic [7:0] cmd;
    } exp_t;
    exp_t q[$];
    exp_t ce;
    logic m_ready = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

    uart_rx_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .busy(busy), .shift(shift), .bit_cnt(bit_cnt),
        .rx_sync(rx_sync), .ready(ready), .rd_ack(rd_ack), .clr_err(clr_err),
        .start(start), .receiving(receiving), .clr_busy(clr_busy),
        .set_ready(set_ready), .clr_ready(clr_ready), .frame_err(frame_err),
        .overrun(overrun), .state(state)
    );

    always #5 clk = ~clk;

    // stand-in for the datapath: ready flag (clear wins) and LSB-first byte capture
    always @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            sh <= 8'h00;
            cmd <= 8'h00;
        end else begin
            ready <= clr_ready ? 1'b0 : set_ready ? 1'b1 : ready;
            if (shift && receiving && bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                sh <= {rx_sync, sh[7:1]};
            if (receiving && bit_cnt == 4'd10)
                cmd <= sh;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int recv_n = 0;
    bit pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            recv_n = 0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("clr_busy_width", clr_busy, 0);
                chk("frame_err", frame_err, ce.fe);
                chk("overrun", overrun, ce.ov);
                chk("ready_after", ready, ce.rdy);
                pend = 1'b0;
            end
            if (start) recv_n = 0;
            if (receiving) recv_n++;
            if (set_ready && !clr_busy) begin
                checks++;
                errs++;
                $display("FAIL stray_set_ready: state=%0d", state);
            end
            if (clr_busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_clr_busy: state=%0d", state);
                end else begin
                    ce = q.pop_front();
                    chk("end_state", state, ce.kind == 0 ? 3 : ce.kind == 1 ? 5 : 4);
                    chk("set_ready", set_ready, ce.sr);
                    chk("clr_ready", clr_ready, ce.cr);
                    if (ce.kind == 0) chk("cmd", cmd, ce.cmd);
                    if (ce.kind == 2) chk("timeout_len", recv_n, TIMEOUT);
                    pend = 1'b1;
                end
            end
        end
    end

    // kind: 0 full frame, 1 start-bit glitch, 2 stall until timeout
    task automatic frame(input logic [7:0] d, input bit stop, input int kind, input bit ack);
        exp_t e;
        logic [9:0] fr;
        int n;
        e.kind = kind;
        e.sr = 1'b0;
        e.cr = 1'b0;
        e.cmd = d;
        if (kind == 0 && stop) begin
            e.sr = 1'b1;
            m_ov = m_ov | (m_ready & ~ack);
            m_ready = 1'b1;
        end else if (kind == 0) begin
            e.cr = ack;
            m_fe = 1'b1;
            if (ack) m_ready = 1'b0;
        end else if (kind == 2) begin
            m_fe = 1'b1;
        end
        e.fe = m_fe;
        e.ov = m_ov;
        e.rdy = m_ready;
        q.push_back(e);
        fr = {stop, d, kind == 1};
        busy = 1'b1;
        tick();
        chk("start_pulse", {start, receiving}, 2'b10);
        tick();
        chk("start_once", {start, receiving}, 2'b01);
        for (int b = 0; b < 10; b++) begin
            if (kind == 2 && b == 4) break;
            repeat (B - 1) tick();
            shift = 1'b1;
            bit_cnt = 4'(b);
            rx_sync = fr[b];
            tick();
            shift = 1'b0;
            bit_cnt = 4'(b + 1);
            if (kind == 1) break;
        end
        if (kind == 0) tick();
        if (kind == 2) begin
            n = 0;
            while (!clr_busy && n < TIMEOUT + 50) begin
                tick();
                n++;
            end
            if (!clr_busy) begin
                checks++;
                errs++;
                $display("FAIL abort_wait: no clr_busy after %0d cycles", n);
            end
        end
        rd_ack = (kind == 0) ? ack : 1'b0;
        busy = 1'b0;
        bit_cnt = 4'd0;
        rx_sync = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        m_ready = 1'b0;
        chk("ready_acked", ready, 0);
    endtask

    task automatic clr_err_pulse();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        chk("clr_err_fe", frame_err, 0);
        chk("clr_err_ov", overrun, 0);
    endtask

    task automatic reset_mid_frame(input logic [7:0] d);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        busy = 1'b1;
        tick();
        tick();
        for (int b = 0; b < 5; b++) begin
            repeat (B - 1) tick();
            shift = 1'b1;
            bit_cnt = 4'(b);
            rx_sync = fr[b];
            tick();
            shift = 1'b0;
            bit_cnt = 4'(b + 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy = 1'b0;
        bit_cnt = 4'd0;
        rx_sync = 1'b1;
        m_ready = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_ctrl", {start, receiving, clr_busy, set_ready}, 0);
        chk("rst_flags", {frame_err, overrun}, 0);
        chk("rst_ready", ready, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, kind;
        tick();
        tick();
        chk("reset_state", state, 0);
        chk("reset_ctrl", {start, receiving, clr_busy, set_ready, clr_ready}, 0);
        chk("reset_flags", {frame_err, overrun}, 0);
        rst = 1'b0;
        tick();
        chk("idle_state", state, 0);
        frame(8'hA5, 1'b1, 0, 1'b0);
        frame(8'h00, 1'b1, 1, 1'b0);
        frame(8'h3C, 1'b0, 0, 1'b0);
        repeat (3) tick();
        chk("fe_sticky", frame_err, 1);
        clr_err_pulse();
        ack_pulse();
        frame(8'h11, 1'b1, 0, 1'b0);
        frame(8'h22, 1'b1, 0, 1'b0);
        clr_err_pulse();
        ack_pulse();
        frame(8'h33, 1'b1, 0, 1'b0);
        frame(8'h44, 1'b1, 0, 1'b1);
        frame(8'h00, 1'b1, 2, 1'b0);
        tick();
        chk("abort_state", state, 0);
        reset_mid_frame(8'h77);
        frame(8'h5A, 1'b1, 0, 1'b0);
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            kind = r < 7 ? 0 : r < 9 ? 1 : 2;
            frame(8'($urandom), ($urandom % 4) != 0, kind, ($urandom % 3) == 0);
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom % 3 == 0) ack_pulse();
            if ($urandom % 4 == 0) clr_err_pulse();
        end
        repeat (4) tick();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
